// File: rtl/syn_gpu_pkg.sv
// Shared GPU types: pixel format, frame geometry and the frame-buffer bridge FSM encoding.
package syn_gpu_pkg;

    localparam int C_FRAME_W = 640;
    localparam int C_FRAME_H = 480;
    localparam int P_POS_W   = 12;
    localparam int P_MISC_W  = 8;

    typedef struct packed {
        logic [7:0] y;
        logic [7:0] cb;
        logic [7:0] cr;
    } pxl_ycbcr_t;

    localparam int P_PXL_W = $bits(pxl_ycbcr_t);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RD2  = 1'b1
    } fb_brdg_fsm_t;

endpackage

// File: rtl/syn_pxl_xfr_intf.sv
// Pixel transfer interface between grapheme pipeline stages.
// valid/ready: a transfer happens on a clock edge where ready=1 and either valid is 1; the
// master holds all payload stable while a valid is up and ready is 0.
interface syn_pxl_xfr_intf;
    import syn_gpu_pkg::*;

    logic                pxl_wr_valid;
    logic                pxl_rd_valid;
    logic                ready;
    pxl_ycbcr_t          pxl;
    logic [P_POS_W-1:0]  posx;
    logic [P_POS_W-1:0]  posy;
    logic [P_MISC_W-1:0] misc_info_dist;
    logic [P_MISC_W-1:0] misc_info_norm;

    modport master (
        output pxl_wr_valid, pxl_rd_valid, pxl, posx, posy, misc_info_dist, misc_info_norm,
        input  ready
    );

    modport slave (
        input  pxl_wr_valid, pxl_rd_valid, pxl, posx, posy, misc_info_dist, misc_info_norm,
        output ready
    );

endinterface

// File: rtl/syn_pxl_rd_buf.sv
// In-order read response buffer: entries are allocated at request time and filled by memory
// read data in allocation order; out-of-range reads are allocated already filled.
module syn_pxl_rd_buf
    import syn_gpu_pkg::*;
#(
    parameter  int P_DEPTH = 4,
    localparam int P_PTR_W = $clog2(P_DEPTH),
    localparam int P_CNT_W = $clog2(P_DEPTH + 1)
) (
    input  logic               clk_ir,
    input  logic               rst_il,
    input  logic               alloc_i,
    input  logic               alloc_filled_i,
    input  logic [P_POS_W-1:0] alloc_posx_i,
    input  logic [P_POS_W-1:0] alloc_posy_i,
    input  logic               fill_i,
    input  logic [P_PXL_W-1:0] fill_pxl_i,
    input  logic               pop_i,
    output logic               head_valid_o,
    output logic [P_PXL_W-1:0] head_pxl_o,
    output logic [P_POS_W-1:0] head_posx_o,
    output logic [P_POS_W-1:0] head_posy_o,
    output logic [P_CNT_W-1:0] free_cnt_o
);

    logic [P_PTR_W-1:0] head_q, head_d, tail_q, tail_d, fill_ptr, idx;
    logic [P_CNT_W-1:0] count_q, count_d;
    logic               filled_q [P_DEPTH];
    logic [P_PXL_W-1:0] pxl_q    [P_DEPTH];
    logic [P_POS_W-1:0] posx_q   [P_DEPTH];
    logic [P_POS_W-1:0] posy_q   [P_DEPTH];
    logic               fill_hit, pop;

    // Oldest occupied entry still waiting for memory data; oob entries are skipped.
    always_comb begin
        fill_hit = 1'b0;
        fill_ptr = head_q;
        idx      = '0;
        for (int i = P_DEPTH - 1; i >= 0; i--) begin
            idx = head_q + P_PTR_W'(i);
            if ((P_CNT_W'(i) < count_q) && !filled_q[idx]) begin
                fill_hit = 1'b1;
                fill_ptr = idx;
            end
        end
    end

    assign head_valid_o = (count_q != '0) && filled_q[head_q];
    assign head_pxl_o   = pxl_q[head_q];
    assign head_posx_o  = posx_q[head_q];
    assign head_posy_o  = posy_q[head_q];
    assign free_cnt_o   = P_CNT_W'(P_DEPTH) - count_q;

    assign pop     = pop_i && head_valid_o;
    assign head_d  = pop ? head_q + 1'b1 : head_q;
    assign tail_d  = alloc_i ? tail_q + 1'b1 : tail_q;
    assign count_d = count_q + P_CNT_W'(alloc_i) - P_CNT_W'(pop);

    always_ff @(posedge clk_ir or negedge rst_il) begin
        if (!rst_il) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < P_DEPTH; i++) begin
                filled_q[i] <= 1'b0;
                pxl_q[i]    <= '0;
                posx_q[i]   <= '0;
                posy_q[i]   <= '0;
            end
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            if (alloc_i) begin
                filled_q[tail_q] <= alloc_filled_i;
                pxl_q[tail_q]    <= '0;
                posx_q[tail_q]   <= alloc_posx_i;
                posy_q[tail_q]   <= alloc_posy_i;
            end
            if (fill_i && fill_hit) begin
                filled_q[fill_ptr] <= 1'b1;
                pxl_q[fill_ptr]    <= fill_pxl_i;
            end
        end
    end

    a_fill_has_entry: assert property (@(posedge clk_ir) disable iff (!rst_il) fill_i |-> fill_hit);

endmodule

// File: rtl/syn_pxl_fb_bridge.sv
// Frame-buffer bridge: maps (posx, posy) pixel requests onto a linear memory bus and returns
// read data in request order.
module syn_pxl_fb_bridge
    import syn_gpu_pkg::*;
#(
    parameter int P_FB_W     = C_FRAME_W,
    parameter int P_FB_H     = C_FRAME_H,
    parameter int P_ADDR_W   = 19,
    parameter int P_RD_DEPTH = 4
) (
    input  logic                clk_ir,
    input  logic                rst_il,
    syn_pxl_xfr_intf.slave      req,
    syn_pxl_xfr_intf.master     rsp,
    output logic [P_ADDR_W-1:0] fb_addr,
    output logic [P_PXL_W-1:0]  fb_wdata,
    output logic                fb_wr_en,
    output logic                fb_rd_en,
    input  logic                fb_wait,
    input  logic                fb_rd_valid,
    input  logic [P_PXL_W-1:0]  fb_rd_data,
    output logic                err_oob,
    output fb_brdg_fsm_t        dbg_state
);

    localparam int P_CNT_W = $clog2(P_RD_DEPTH + 1);

    fb_brdg_fsm_t        state_q, state_d;
    logic [P_ADDR_W-1:0] addr_q, addr_d, req_addr;
    logic [P_PXL_W-1:0]  wdata_q, wdata_d;
    logic                wr_en_q, wr_en_d, rd_en_q, rd_en_d, err_q, err_d;
    logic                rdy_en_q, ready, accept, oob, cmd_stalled;
    logic                alloc, alloc_filled;
    logic [P_CNT_W-1:0]  free_cnt;

    assign req_addr    = P_ADDR_W'(req.posy) * P_ADDR_W'(P_FB_W) + P_ADDR_W'(req.posx);
    assign oob         = (32'(req.posx) >= P_FB_W) || (32'(req.posy) >= P_FB_H);
    assign cmd_stalled = (wr_en_q || rd_en_q) && fb_wait;
    assign ready       = rdy_en_q && (state_q == IDLE) && !cmd_stalled && (free_cnt != '0);
    assign accept      = ready && (req.pxl_wr_valid || req.pxl_rd_valid);

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        wr_en_d      = wr_en_q;
        rd_en_d      = rd_en_q;
        err_d        = 1'b0;
        alloc        = 1'b0;
        alloc_filled = 1'b0;
        if (!cmd_stalled) begin
            wr_en_d = 1'b0;
            rd_en_d = 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        alloc        = req.pxl_rd_valid;
                        alloc_filled = oob;
                        if (oob) begin
                            err_d = 1'b1;
                        end else if (req.pxl_wr_valid) begin
                            addr_d  = req_addr;
                            wdata_d = req.pxl;
                            wr_en_d = 1'b1;
                            // The read half reuses addr_q once the write has left.
                            if (req.pxl_rd_valid) state_d = RD2;
                        end else begin
                            addr_d  = req_addr;
                            rd_en_d = 1'b1;
                        end
                    end
                end
                RD2: begin
                    rd_en_d = 1'b1;
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_ir or negedge rst_il) begin
        if (!rst_il) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            wdata_q  <= '0;
            wr_en_q  <= 1'b0;
            rd_en_q  <= 1'b0;
            err_q    <= 1'b0;
            rdy_en_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            wr_en_q  <= wr_en_d;
            rd_en_q  <= rd_en_d;
            err_q    <= err_d;
            rdy_en_q <= 1'b1;
        end
    end

    syn_pxl_rd_buf #(.P_DEPTH(P_RD_DEPTH)) u_rd_buf (
        .clk_ir         (clk_ir),
        .rst_il         (rst_il),
        .alloc_i        (alloc),
        .alloc_filled_i (alloc_filled),
        .alloc_posx_i   (req.posx),
        .alloc_posy_i   (req.posy),
        .fill_i         (fb_rd_valid),
        .fill_pxl_i     (fb_rd_data),
        .pop_i          (rsp.ready),
        .head_valid_o   (rsp.pxl_rd_valid),
        .head_pxl_o     (rsp.pxl),
        .head_posx_o    (rsp.posx),
        .head_posy_o    (rsp.posy),
        .free_cnt_o     (free_cnt)
    );

    assign req.ready          = ready;
    assign rsp.pxl_wr_valid   = 1'b0;
    assign rsp.misc_info_dist = '0;
    assign rsp.misc_info_norm = '0;
    assign fb_addr            = addr_q;
    assign fb_wdata           = wdata_q;
    assign fb_wr_en           = wr_en_q;
    assign fb_rd_en           = rd_en_q;
    assign err_oob            = err_q;
    assign dbg_state          = state_q;

endmodule

// File: tb/tb_syn_pxl_fb_bridge.sv
// Directed bench for syn_pxl_fb_bridge with a fixed-latency frame-buffer read model.
module tb_syn_pxl_fb_bridge;
    import syn_gpu_pkg::*;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic [18:0]        fb_addr;
    logic [P_PXL_W-1:0] fb_wdata;
    logic               fb_wr_en, fb_rd_en, err_oob;
    logic               fb_wait = 1'b0;
    logic               fb_rd_valid = 1'b0;
    logic [P_PXL_W-1:0] fb_rd_data = '0;
    fb_brdg_fsm_t       dbg_state;

    int n_cmp = 0;
    int n_mis = 0;

    syn_pxl_xfr_intf req_if ();
    syn_pxl_xfr_intf rsp_if ();

    syn_pxl_fb_bridge dut (
        .clk_ir      (clk),
        .rst_il      (rst_n),
        .req         (req_if),
        .rsp         (rsp_if),
        .fb_addr     (fb_addr),
        .fb_wdata    (fb_wdata),
        .fb_wr_en    (fb_wr_en),
        .fb_rd_en    (fb_rd_en),
        .fb_wait     (fb_wait),
        .fb_rd_valid (fb_rd_valid),
        .fb_rd_data  (fb_rd_data),
        .err_oob     (err_oob),
        .dbg_state   (dbg_state)
    );

    // Clock and watchdog
    initial forever #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Memory model: a read taken in one cycle returns data two falling edges later, so the
    // bridge samples fb_rd_valid on the third rising edge after the read was issued.
    logic               pipe_v [3];
    logic [P_PXL_W-1:0] pipe_d [3];
    initial begin
        for (int i = 0; i < 3; i++) begin pipe_v[i] = 1'b0; pipe_d[i] = '0; end
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                for (int i = 0; i < 3; i++) begin pipe_v[i] = 1'b0; pipe_d[i] = '0; end
                fb_rd_valid = 1'b0;
                fb_rd_data  = '0;
            end else begin
                pipe_v[2] = pipe_v[1]; pipe_d[2] = pipe_d[1];
                pipe_v[1] = pipe_v[0]; pipe_d[1] = pipe_d[0];
                pipe_v[0] = fb_rd_en && !fb_wait;
                pipe_d[0] = 24'hA00000 | {5'd0, fb_addr};
                fb_rd_valid = pipe_v[2];
                fb_rd_data  = pipe_v[2] ? pipe_d[2] : '0;
            end
        end
    end

    // Driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_req();
        req_if.pxl_wr_valid   = 1'b0;
        req_if.pxl_rd_valid   = 1'b0;
        req_if.pxl            = '0;
        req_if.posx           = '0;
        req_if.posy           = '0;
        req_if.misc_info_dist = '0;
        req_if.misc_info_norm = '0;
    endtask

    task automatic drive_req(input logic wr, input logic rd, input int x, input int y,
                             input logic [23:0] p);
        req_if.pxl_wr_valid = wr;
        req_if.pxl_rd_valid = rd;
        req_if.posx         = 12'(x);
        req_if.posy         = 12'(y);
        req_if.pxl          = p;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clr_req();
        rsp_if.ready = 1'b0;
        fb_wait = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++; if (fb_addr !== 19'd0) begin n_mis++; $display("FAIL rst_fb_addr: got %0d want 0", fb_addr); end
        n_cmp++; if (fb_wdata !== 24'd0) begin n_mis++; $display("FAIL rst_fb_wdata: got %h want 0", fb_wdata); end
        n_cmp++; if (fb_wr_en !== 1'b0 || fb_rd_en !== 1'b0) begin n_mis++; $display("FAIL rst_strobes: got wr=%b rd=%b want 0 0", fb_wr_en, fb_rd_en); end
        n_cmp++; if (err_oob !== 1'b0) begin n_mis++; $display("FAIL rst_err: got %b want 0", err_oob); end
        n_cmp++; if (req_if.ready !== 1'b0) begin n_mis++; $display("FAIL rst_ready: got %b want 0", req_if.ready); end
        n_cmp++; if (rsp_if.pxl_rd_valid !== 1'b0) begin n_mis++; $display("FAIL rst_rsp_valid: got %b want 0", rsp_if.pxl_rd_valid); end
        n_cmp++; if (rsp_if.pxl !== 24'd0 || rsp_if.posx !== 12'd0 || rsp_if.posy !== 12'd0) begin
            n_mis++; $display("FAIL rst_rsp_payload: got %h/%0d/%0d want 0/0/0", rsp_if.pxl, rsp_if.posx, rsp_if.posy); end
        n_cmp++; if (rsp_if.pxl_wr_valid !== 1'b0) begin n_mis++; $display("FAIL rst_rsp_wr_valid: got %b want 0", rsp_if.pxl_wr_valid); end
        n_cmp++; if (dbg_state !== IDLE) begin n_mis++; $display("FAIL rst_state: got %0d want IDLE", dbg_state); end
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++; if (req_if.ready !== 1'b0) begin n_mis++; $display("FAIL rel_ready_early: got %b want 0", req_if.ready); end
        tick();
        @(negedge clk);
        n_cmp++; if (req_if.ready !== 1'b1) begin n_mis++; $display("FAIL rel_ready_up: got %b want 1", req_if.ready); end
        tick();
    endtask

    task automatic test_write();
        drive_req(1'b1, 1'b0, 3, 2, 24'h112233);
        @(negedge clk);
        n_cmp++; if (req_if.ready !== 1'b1) begin n_mis++; $display("FAIL wr_ready: got %b want 1", req_if.ready); end
        tick();
        clr_req();
        @(negedge clk);
        n_cmp++; if (fb_wr_en !== 1'b1 || fb_rd_en !== 1'b0) begin n_mis++; $display("FAIL wr_strobe: got wr=%b rd=%b want 1 0", fb_wr_en, fb_rd_en); end
        n_cmp++; if (fb_addr !== 19'd1283) begin n_mis++; $display("FAIL wr_addr: got %0d want 1283", fb_addr); end
        n_cmp++; if (fb_wdata !== 24'h112233) begin n_mis++; $display("FAIL wr_data: got %h want 112233", fb_wdata); end
        n_cmp++; if (err_oob !== 1'b0) begin n_mis++; $display("FAIL wr_err: got %b want 0", err_oob); end
        tick();
        @(negedge clk);
        n_cmp++; if (fb_wr_en !== 1'b0) begin n_mis++; $display("FAIL wr_strobe_off: got %b want 0", fb_wr_en); end
        tick();
    endtask

    task automatic test_read_burst();
        logic [11:0] exp_q[$];
        int sent = 0;
        int got = 0;
        int acc5 = -1;
        logic acc;
        rsp_if.ready = 1'b1;
        for (int cyc = 0; cyc < 40 && got < 5; cyc++) begin
            if (sent < 5) drive_req(1'b0, 1'b1, sent, 0, 24'h0);
            else clr_req();
            @(negedge clk);
            if (cyc == 4) begin
                n_cmp++; if (req_if.ready !== 1'b0) begin n_mis++; $display("FAIL burst_full_ready: got %b want 0", req_if.ready); end
            end
            acc = req_if.pxl_rd_valid && req_if.ready;
            if (rsp_if.pxl_rd_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_cmp++; n_mis++; $display("FAIL burst_extra_rsp: got posx %0d want none", rsp_if.posx);
                end else begin
                    n_cmp++; if (rsp_if.posx !== exp_q[0] || rsp_if.posy !== 12'd0) begin
                        n_mis++; $display("FAIL burst_pos: got (%0d,%0d) want (%0d,0)", rsp_if.posx, rsp_if.posy, exp_q[0]); end
                    n_cmp++; if (rsp_if.pxl !== (24'hA00000 | {12'd0, exp_q[0]})) begin
                        n_mis++; $display("FAIL burst_pxl: got %h want %h", rsp_if.pxl, 24'hA00000 | {12'd0, exp_q[0]}); end
                    void'(exp_q.pop_front());
                end
                got++;
            end
            if (acc) begin
                exp_q.push_back(12'(sent));
                if (sent == 4) acc5 = cyc;
                sent++;
            end
            tick();
        end
        clr_req();
        n_cmp++; if (got != 5) begin n_mis++; $display("FAIL burst_count: got %0d want 5", got); end
        n_cmp++; if (acc5 != 5) begin n_mis++; $display("FAIL burst_5th_accept_cycle: got %0d want 5", acc5); end
    endtask

    task automatic test_dual();
        int got = 0;
        rsp_if.ready = 1'b1;
        drive_req(1'b1, 1'b1, 10, 10, 24'h0A0B0C);
        @(negedge clk);
        n_cmp++; if (req_if.ready !== 1'b1) begin n_mis++; $display("FAIL dual_ready: got %b want 1", req_if.ready); end
        tick();
        clr_req();
        @(negedge clk);
        n_cmp++; if (fb_wr_en !== 1'b1 || fb_rd_en !== 1'b0 || fb_addr !== 19'd6410) begin
            n_mis++; $display("FAIL dual_write: got wr=%b rd=%b addr=%0d want 1 0 6410", fb_wr_en, fb_rd_en, fb_addr); end
        n_cmp++; if (fb_wdata !== 24'h0A0B0C) begin n_mis++; $display("FAIL dual_wdata: got %h want 0a0b0c", fb_wdata); end
        n_cmp++; if (req_if.ready !== 1'b0 || dbg_state !== RD2) begin
            n_mis++; $display("FAIL dual_rd2: got ready=%b state=%0d want 0 RD2", req_if.ready, dbg_state); end
        tick();
        @(negedge clk);
        n_cmp++; if (fb_rd_en !== 1'b1 || fb_wr_en !== 1'b0 || fb_addr !== 19'd6410) begin
            n_mis++; $display("FAIL dual_read: got wr=%b rd=%b addr=%0d want 0 1 6410", fb_wr_en, fb_rd_en, fb_addr); end
        n_cmp++; if (req_if.ready !== 1'b1 || dbg_state !== IDLE) begin
            n_mis++; $display("FAIL dual_back_idle: got ready=%b state=%0d want 1 IDLE", req_if.ready, dbg_state); end
        tick();
        for (int cyc = 0; cyc < 20 && got == 0; cyc++) begin
            @(negedge clk);
            if (rsp_if.pxl_rd_valid === 1'b1) begin
                got++;
                n_cmp++; if (rsp_if.posx !== 12'd10 || rsp_if.posy !== 12'd10 || rsp_if.pxl !== 24'hA0190A) begin
                    n_mis++; $display("FAIL dual_rsp: got (%0d,%0d) %h want (10,10) a0190a", rsp_if.posx, rsp_if.posy, rsp_if.pxl); end
            end
            tick();
        end
        n_cmp++; if (got != 1) begin n_mis++; $display("FAIL dual_rsp_timeout: got %0d responses want 1", got); end
    endtask

    task automatic test_oob();
        logic [11:0] xs [3];
        logic [23:0] ps [3];
        int sent = 0;
        int got = 0;
        xs[0] = 12'd1;   ps[0] = 24'hA00001;
        xs[1] = 12'd640; ps[1] = 24'h000000;
        xs[2] = 12'd2;   ps[2] = 24'hA00002;
        rsp_if.ready = 1'b1;
        drive_req(1'b1, 1'b0, 0, 480, 24'hFFFFFF);
        @(negedge clk);
        n_cmp++; if (req_if.ready !== 1'b1) begin n_mis++; $display("FAIL oobw_ready: got %b want 1", req_if.ready); end
        tick();
        clr_req();
        @(negedge clk);
        n_cmp++; if (err_oob !== 1'b1 || fb_wr_en !== 1'b0) begin
            n_mis++; $display("FAIL oobw_drop: got err=%b wr=%b want 1 0", err_oob, fb_wr_en); end
        tick();
        @(negedge clk);
        n_cmp++; if (err_oob !== 1'b0) begin n_mis++; $display("FAIL oobw_pulse: got %b want 0", err_oob); end
        tick();
        for (int cyc = 0; cyc < 30 && got < 3; cyc++) begin
            if (sent < 3) drive_req(1'b0, 1'b1, int'(xs[sent]), 0, 24'h0);
            else clr_req();
            @(negedge clk);
            if (cyc == 1) begin
                n_cmp++; if (fb_rd_en !== 1'b1 || fb_addr !== 19'd1 || err_oob !== 1'b0) begin
                    n_mis++; $display("FAIL oobr_c1: got rd=%b addr=%0d err=%b want 1 1 0", fb_rd_en, fb_addr, err_oob); end
            end
            if (cyc == 2) begin
                n_cmp++; if (fb_rd_en !== 1'b0 || err_oob !== 1'b1) begin
                    n_mis++; $display("FAIL oobr_c2: got rd=%b err=%b want 0 1", fb_rd_en, err_oob); end
            end
            if (cyc == 3) begin
                n_cmp++; if (fb_rd_en !== 1'b1 || fb_addr !== 19'd2 || err_oob !== 1'b0) begin
                    n_mis++; $display("FAIL oobr_c3: got rd=%b addr=%0d err=%b want 1 2 0", fb_rd_en, fb_addr, err_oob); end
            end
            if (rsp_if.pxl_rd_valid === 1'b1) begin
                n_cmp++; if (rsp_if.posx !== xs[got] || rsp_if.pxl !== ps[got]) begin
                    n_mis++; $display("FAIL oobr_rsp%0d: got posx=%0d pxl=%h want %0d %h", got, rsp_if.posx, rsp_if.pxl, xs[got], ps[got]); end
                got++;
            end
            if (req_if.pxl_rd_valid && req_if.ready) sent++;
            tick();
        end
        clr_req();
        n_cmp++; if (got != 3) begin n_mis++; $display("FAIL oobr_count: got %0d want 3", got); end
    endtask

    task automatic test_wait();
        int ncomp = 0;
        drive_req(1'b1, 1'b0, 5, 1, 24'h445566);
        @(negedge clk);
        n_cmp++; if (req_if.ready !== 1'b1) begin n_mis++; $display("FAIL wait_ready_in: got %b want 1", req_if.ready); end
        tick();
        clr_req();
        fb_wait = 1'b1;
        for (int c = 1; c <= 7; c++) begin
            if (c == 6) fb_wait = 1'b0;
            @(negedge clk);
            if (fb_wr_en && !fb_wait) ncomp++;
            if (c <= 5) begin
                n_cmp++; if (fb_wr_en !== 1'b1 || fb_addr !== 19'd645 || fb_wdata !== 24'h445566) begin
                    n_mis++; $display("FAIL wait_hold_c%0d: got wr=%b addr=%0d data=%h want 1 645 445566", c, fb_wr_en, fb_addr, fb_wdata); end
                n_cmp++; if (req_if.ready !== 1'b0) begin n_mis++; $display("FAIL wait_ready_c%0d: got %b want 0", c, req_if.ready); end
            end
            if (c == 7) begin
                n_cmp++; if (fb_wr_en !== 1'b0) begin n_mis++; $display("FAIL wait_done: got %b want 0", fb_wr_en); end
            end
            tick();
        end
        n_cmp++; if (ncomp != 1) begin n_mis++; $display("FAIL wait_completions: got %0d want 1", ncomp); end
    endtask

    task automatic test_reset_mid();
        int got = 0;
        logic sent = 1'b0;
        rsp_if.ready = 1'b1;
        drive_req(1'b0, 1'b1, 0, 1, 24'h0);
        tick();
        drive_req(1'b0, 1'b1, 1, 1, 24'h0);
        tick();
        clr_req();
        #1 rst_n = 1'b0;
        #1;
        n_cmp++; if (fb_rd_en !== 1'b0 || fb_wr_en !== 1'b0 || fb_addr !== 19'd0) begin
            n_mis++; $display("FAIL mid_rst_fb: got rd=%b wr=%b addr=%0d want 0 0 0", fb_rd_en, fb_wr_en, fb_addr); end
        n_cmp++; if (req_if.ready !== 1'b0 || err_oob !== 1'b0 || dbg_state !== IDLE) begin
            n_mis++; $display("FAIL mid_rst_ctl: got ready=%b err=%b state=%0d want 0 0 IDLE", req_if.ready, err_oob, dbg_state); end
        n_cmp++; if (rsp_if.pxl_rd_valid !== 1'b0 || rsp_if.posy !== 12'd0) begin
            n_mis++; $display("FAIL mid_rst_rsp: got valid=%b posy=%0d want 0 0", rsp_if.pxl_rd_valid, rsp_if.posy); end
        @(posedge clk);
        tick();
        rst_n = 1'b1;
        tick();
        for (int cyc = 0; cyc < 12; cyc++) begin
            if (!sent) drive_req(1'b0, 1'b1, 7, 2, 24'h0);
            else clr_req();
            @(negedge clk);
            if (rsp_if.pxl_rd_valid === 1'b1) begin
                n_cmp++; if (rsp_if.posx !== 12'd7 || rsp_if.posy !== 12'd2 || rsp_if.pxl !== 24'hA00507) begin
                    n_mis++; $display("FAIL mid_rsp: got (%0d,%0d) %h want (7,2) a00507", rsp_if.posx, rsp_if.posy, rsp_if.pxl); end
                got++;
            end
            if (req_if.pxl_rd_valid && req_if.ready) sent = 1'b1;
            tick();
        end
        clr_req();
        n_cmp++; if (got != 1) begin n_mis++; $display("FAIL mid_rsp_count: got %0d want 1", got); end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read_burst();
        test_dual();
        test_oob();
        test_wait();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
